// File: rtl/codificador_bcd7seg.sv
// Registered BCD/hex to seven-segment encoder with lamp test, blanking and
// invalid-code flag. One instance per digit; outputs change only on clk rising edge.
module codificador_bcd7seg #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] BCD,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] DISPLAY,
  output logic       valid,
  output logic       invalid_code
);

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_ALL  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h01;

  logic [6:0] seg_lut;
  logic       code_hex;

  // Logical pattern, 1 = lit, bit6..bit0 = a..g
  always_comb begin
    seg_lut = SEG_OFF;
    case (BCD)
      4'd0:  seg_lut = 7'h7E;
      4'd1:  seg_lut = 7'h30;
      4'd2:  seg_lut = 7'h6D;
      4'd3:  seg_lut = 7'h79;
      4'd4:  seg_lut = 7'h33;
      4'd5:  seg_lut = 7'h5B;
      4'd6:  seg_lut = 7'h5F;
      4'd7:  seg_lut = 7'h70;
      4'd8:  seg_lut = 7'h7F;
      4'd9:  seg_lut = 7'h7B;
      4'd10: seg_lut = HEX_MODE ? 7'h77 : SEG_DASH;
      4'd11: seg_lut = HEX_MODE ? 7'h1F : SEG_DASH;
      4'd12: seg_lut = HEX_MODE ? 7'h4E : SEG_DASH;
      4'd13: seg_lut = HEX_MODE ? 7'h3D : SEG_DASH;
      4'd14: seg_lut = HEX_MODE ? 7'h4F : SEG_DASH;
      4'd15: seg_lut = HEX_MODE ? 7'h47 : SEG_DASH;
      default: seg_lut = SEG_OFF;
    endcase
  end

  assign code_hex = (BCD >= 4'd10);

  // Polarity is folded into the register so DISPLAY is a pure flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      DISPLAY      <= SEG_OFF ^ {7{ACTIVE_LOW}};
      valid        <= 1'b0;
      invalid_code <= 1'b0;
    end else if (lamp_test) begin
      DISPLAY      <= SEG_ALL ^ {7{ACTIVE_LOW}};
      valid        <= 1'b1;
      invalid_code <= 1'b0;
    end else if (en) begin
      valid <= 1'b1;
      if (blank) begin
        DISPLAY      <= SEG_OFF ^ {7{ACTIVE_LOW}};
        invalid_code <= 1'b0;
      end else begin
        DISPLAY      <= seg_lut ^ {7{ACTIVE_LOW}};
        invalid_code <= code_hex;
      end
    end
  end

endmodule

// File: tb/tb_codificador_bcd7seg.sv
// Directed bench for codificador_bcd7seg: default, dash-mode and common-anode
// instances share one stimulus set; each task checks the instance it targets.
module tb_codificador_bcd7seg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] BCD;
  logic       blank;
  logic       lamp_test;

  logic [6:0] disp_std, disp_dash, disp_al;
  logic       valid_std, valid_dash, valid_al;
  logic       inv_std, inv_dash, inv_al;

  int checks;
  int errors;

  codificador_bcd7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_std (
    .clk(clk), .rst(rst), .en(en), .BCD(BCD), .blank(blank), .lamp_test(lamp_test),
    .DISPLAY(disp_std), .valid(valid_std), .invalid_code(inv_std)
  );

  codificador_bcd7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dash (
    .clk(clk), .rst(rst), .en(en), .BCD(BCD), .blank(blank), .lamp_test(lamp_test),
    .DISPLAY(disp_dash), .valid(valid_dash), .invalid_code(inv_dash)
  );

  codificador_bcd7seg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_al (
    .clk(clk), .rst(rst), .en(en), .BCD(BCD), .blank(blank), .lamp_test(lamp_test),
    .DISPLAY(disp_al), .valid(valid_al), .invalid_code(inv_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are then changed well before the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; BCD = 4'd8; lamp_test = 1'b1; blank = 1'b0;
    step();
    step();
    checks++;
    if (disp_std !== 7'h00) begin errors++; $display("FAIL reset_display got %h want %h", disp_std, 7'h00); end
    checks++;
    if (valid_std !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_std); end
    checks++;
    if (inv_std !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", inv_std); end
    checks++;
    if (disp_al !== 7'h7F) begin errors++; $display("FAIL reset_display_al got %h want %h", disp_al, 7'h7F); end
  endtask

  task automatic test_sweep();
    logic [6:0] exp_seg [16];
    exp_seg = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    rst = 1'b0; lamp_test = 1'b0; blank = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      BCD = 4'(i);
      step();
      checks++;
      if (disp_std !== exp_seg[i]) begin errors++; $display("FAIL sweep_display code %0d got %h want %h", i, disp_std, exp_seg[i]); end
      checks++;
      if (inv_std !== (i >= 10)) begin errors++; $display("FAIL sweep_invalid code %0d got %b want %b", i, inv_std, (i >= 10)); end
      checks++;
      if (valid_std !== 1'b1) begin errors++; $display("FAIL sweep_valid code %0d got %b want 1", i, valid_std); end
    end
  endtask

  task automatic test_dash_mode();
    BCD = 4'd12;
    step();
    checks++;
    if (disp_dash !== 7'h01) begin errors++; $display("FAIL dash_display got %h want %h", disp_dash, 7'h01); end
    checks++;
    if (inv_dash !== 1'b1) begin errors++; $display("FAIL dash_invalid got %b want 1", inv_dash); end
    BCD = 4'd9;
    step();
    checks++;
    if (disp_dash !== 7'h7B) begin errors++; $display("FAIL dash_nine got %h want %h", disp_dash, 7'h7B); end
    checks++;
    if (inv_dash !== 1'b0) begin errors++; $display("FAIL dash_nine_invalid got %b want 0", inv_dash); end
  endtask

  task automatic test_hold_priority();
    BCD = 4'd3; en = 1'b1; blank = 1'b0; lamp_test = 1'b0;
    step();
    checks++;
    if (disp_std !== 7'h79) begin errors++; $display("FAIL hold_load got %h want %h", disp_std, 7'h79); end
    en = 1'b0; BCD = 4'd5;
    step();
    step();
    checks++;
    if (disp_std !== 7'h79) begin errors++; $display("FAIL hold_display got %h want %h", disp_std, 7'h79); end
    blank = 1'b1;
    step();
    checks++;
    if (disp_std !== 7'h79) begin errors++; $display("FAIL hold_blank_disabled got %h want %h", disp_std, 7'h79); end
    blank = 1'b0; lamp_test = 1'b1;
    step();
    checks++;
    if (disp_std !== 7'h7F) begin errors++; $display("FAIL lamp_with_en0 got %h want %h", disp_std, 7'h7F); end
    lamp_test = 1'b0; blank = 1'b1; en = 1'b1;
    step();
    checks++;
    if (disp_std !== 7'h00) begin errors++; $display("FAIL blank_display got %h want %h", disp_std, 7'h00); end
    checks++;
    if (valid_std !== 1'b1) begin errors++; $display("FAIL blank_valid got %b want 1", valid_std); end
    // Invalid flag is cleared by lamp test and by blank
    blank = 1'b0; BCD = 4'd15;
    step();
    checks++;
    if (inv_std !== 1'b1) begin errors++; $display("FAIL hex_invalid got %b want 1", inv_std); end
    lamp_test = 1'b1;
    step();
    checks++;
    if (inv_std !== 1'b0) begin errors++; $display("FAIL lamp_clears_invalid got %b want 0", inv_std); end
    lamp_test = 1'b0;
    step();
    blank = 1'b1;
    step();
    checks++;
    if (inv_std !== 1'b0) begin errors++; $display("FAIL blank_clears_invalid got %b want 0", inv_std); end
    blank = 1'b0;
  endtask

  task automatic test_active_low();
    rst = 1'b1;
    step();
    checks++;
    if (disp_al !== 7'h7F) begin errors++; $display("FAIL al_reset got %h want %h", disp_al, 7'h7F); end
    rst = 1'b0; en = 1'b1; BCD = 4'd0;
    step();
    checks++;
    if (disp_al !== 7'h01) begin errors++; $display("FAIL al_zero got %h want %h", disp_al, 7'h01); end
    BCD = 4'd1;
    step();
    checks++;
    if (disp_al !== 7'h4F) begin errors++; $display("FAIL al_one got %h want %h", disp_al, 7'h4F); end
    lamp_test = 1'b1;
    step();
    checks++;
    if (disp_al !== 7'h00) begin errors++; $display("FAIL al_lamp got %h want %h", disp_al, 7'h00); end
    lamp_test = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; BCD = 4'd4;
    step();
    BCD = 4'd7; lamp_test = 1'b1; rst = 1'b1;
    step();
    checks++;
    if (disp_std !== 7'h00) begin errors++; $display("FAIL midreset_display got %h want %h", disp_std, 7'h00); end
    checks++;
    if (valid_std !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", valid_std); end
    rst = 1'b0;
    step();
    checks++;
    if (disp_std !== 7'h7F) begin errors++; $display("FAIL after_reset_lamp got %h want %h", disp_std, 7'h7F); end
    checks++;
    if (valid_std !== 1'b1) begin errors++; $display("FAIL after_reset_valid got %b want 1", valid_std); end
    lamp_test = 1'b0; BCD = 4'd2;
    step();
    checks++;
    if (disp_std !== 7'h6D) begin errors++; $display("FAIL after_reset_two got %h want %h", disp_std, 7'h6D); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; BCD = 4'd0; blank = 1'b0; lamp_test = 1'b0;
    #1;
    test_reset();
    test_sweep();
    test_dash_mode();
    test_hold_priority();
    test_active_low();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
